// File: rtl/cuthrough_output_arbiter.sv
// Per-output-port round-robin arbiter for the cut-through router.
// Grants one requesting input and holds it until that input's TLAST beat handshakes.
module cuthrough_output_arbiter #(
    parameter int DATA_WIDTH           = 40,
    parameter int ID_WIDTH             = 4,
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNEL_NUMBER-1:0]            req,
    input  logic [CHANNEL_NUMBER-1:0]            in_tvalid,
    input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata,
    input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0]   in_tid,
    input  logic [CHANNEL_NUMBER-1:0]            in_tlast,
    output logic [CHANNEL_NUMBER-1:0]            in_tready,
    output logic                                 out_tvalid,
    output logic [DATA_WIDTH-1:0]                out_tdata,
    output logic [ID_WIDTH-1:0]                  out_tid,
    output logic                                 out_tlast,
    input  logic                                 out_tready,
    output logic [CHANNEL_NUMBER-1:0]            grant,
    output logic                                 busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                          state_q, state_d;
    logic [CHANNEL_NUMBER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CHANNEL_NUMBER_WIDTH-1:0] grant_idx_q, grant_idx_d;

    logic [CHANNEL_NUMBER-1:0]       elig;
    logic [CHANNEL_NUMBER_WIDTH-1:0] pick_hi, pick_lo, winner;
    logic                            found_hi;
    logic                            idx_ok;
    logic                            own;

    // Lowest eligible index at or above rr_ptr wins; otherwise wrap to the lowest eligible overall.
    always_comb begin
        elig     = req & in_tvalid;
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int i = CHANNEL_NUMBER - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick_lo = CHANNEL_NUMBER_WIDTH'(i);
                if (CHANNEL_NUMBER_WIDTH'(i) >= rr_ptr_q) begin
                    pick_hi  = CHANNEL_NUMBER_WIDTH'(i);
                    found_hi = 1'b1;
                end
            end
        end
        winner = found_hi ? pick_hi : pick_lo;
    end

    assign idx_ok = (int'(grant_idx_q) < CHANNEL_NUMBER);
    assign own    = (state_q == BUSY) && idx_ok && !rst;
    assign busy   = own;

    always_comb begin
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tid    = '0;
        out_tlast  = 1'b0;
        in_tready  = '0;
        grant      = '0;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            if (own && (grant_idx_q == CHANNEL_NUMBER_WIDTH'(i))) begin
                grant[i]     = 1'b1;
                out_tvalid   = in_tvalid[i] & req[i];
                out_tdata    = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                out_tid      = in_tid[i*ID_WIDTH +: ID_WIDTH];
                out_tlast    = in_tlast[i];
                in_tready[i] = out_tready;
            end
        end
    end

    // Release happens only on the TLAST handshake; no new grant in that cycle, leaving one bubble.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        if ((state_q == BUSY) && idx_ok) begin
            if (out_tvalid && out_tready && out_tlast) begin
                state_d  = IDLE;
                rr_ptr_d = (grant_idx_q == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1))
                           ? '0 : grant_idx_q + 1'b1;
            end
        end else if (|elig) begin
            state_d     = BUSY;
            grant_idx_d = winner;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

endmodule
